// File: rtl/shift_pkg.sv
// Shared types and sizes for the shift arbiter slice.
//   NREQ       : number of requesters sharing the shifter
//   DW / SHW   : operand width / shift-amount width
//   shift_op_t : one shift operation as presented to the shared shifter
package shift_pkg;

    localparam int unsigned NREQ = 2;
    localparam int unsigned DW   = 8;
    localparam int unsigned SHW  = 3;

    typedef struct packed {
        logic          al;     // 1 = arithmetic right fill
        logic          lr;     // 1 = left, 0 = right
        logic [DW-1:0] din;    // operand
        logic [SHW-1:0] shamt; // shift amount
    } shift_op_t;

endpackage

// File: rtl/barrelshifter.sv
// Combinational 8-bit barrel shifter (log-staged 1/2/4).
//   al    : 1 = arithmetic right (fill din[7]), 0 = logical; ignored on left
//   lr    : 1 = shift left (zero fill), 0 = shift right
//   din   : operand
//   shamt : shift amount 0..7
//   dout  : shifted result
module barrelshifter (
    input  logic       al,
    input  logic       lr,
    input  logic [7:0] din,
    input  logic [2:0] shamt,
    output logic [7:0] dout
);

    logic       fill;
    logic [7:0] s1;
    logic [7:0] s2;

    // Fill bit taken from the original sign so every stage extends it consistently.
    assign fill = lr ? 1'b0 : (al & din[7]);

    // Stage by 1
    always_comb begin
        s1 = din;
        if (shamt[0]) begin
            s1 = lr ? {din[6:0], 1'b0} : {fill, din[7:1]};
        end
    end

    // Stage by 2
    always_comb begin
        s2 = s1;
        if (shamt[1]) begin
            s2 = lr ? {s1[5:0], 2'b00} : {{2{fill}}, s1[7:2]};
        end
    end

    // Stage by 4
    always_comb begin
        dout = s2;
        if (shamt[2]) begin
            dout = lr ? {s2[3:0], 4'b0000} : {{4{fill}}, s2[7:4]};
        end
    end

endmodule

// File: rtl/rr_arb2.sv
// Two-way round-robin grant, purely combinational.
//   elig  : per-requester eligibility
//   last  : index of the requester served most recently
//   grant : one-hot grant, or zero when nobody is eligible
module rr_arb2 (
    input  logic [1:0] elig,
    input  logic       last,
    output logic [1:0] grant
);

    always_comb begin
        grant = 2'b00;
        unique case (elig)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            // Tie goes to the requester not served last.
            2'b11:   grant = last ? 2'b01 : 2'b10;
            default: grant = 2'b00;
        endcase
    end

endmodule

// File: rtl/shift_arbiter.sv
// Shares one barrel shifter between two valid/ready requesters.
// A round-robin grant picks at most one request per cycle; the shifter
// result lands in that requester's one-entry response buffer and is
// presented the following cycle.
//   clk, rst              : clock, asynchronous active-high reset
//   reqN_valid/ready      : request handshake (ready is combinational)
//   reqN_al/lr/din/shamt  : shift operation for requester N
//   rspN_valid/ready      : response handshake
//   rspN_dout             : buffered shift result
module shift_arbiter
    import shift_pkg::*;
#(
    parameter bit RR_INIT = 1'b1
) (
    input  logic                clk,
    input  logic                rst,

    input  logic                req0_valid,
    output logic                req0_ready,
    input  logic                req0_al,
    input  logic                req0_lr,
    input  logic [DW-1:0]       req0_din,
    input  logic [SHW-1:0]      req0_shamt,
    output logic                rsp0_valid,
    input  logic                rsp0_ready,
    output logic [DW-1:0]       rsp0_dout,

    input  logic                req1_valid,
    output logic                req1_ready,
    input  logic                req1_al,
    input  logic                req1_lr,
    input  logic [DW-1:0]       req1_din,
    input  logic [SHW-1:0]      req1_shamt,
    output logic                rsp1_valid,
    input  logic                rsp1_ready,
    output logic [DW-1:0]       rsp1_dout
);

    shift_op_t         op0;
    shift_op_t         op1;
    shift_op_t         sh_op;
    logic [DW-1:0]     sh_dout;

    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   rsp_ready;
    logic [NREQ-1:0]   elig;
    logic [NREQ-1:0]   grant;
    logic [NREQ-1:0]   accept;

    logic              last;
    logic [NREQ-1:0]   rsp_valid_q;
    logic [DW-1:0]     rsp_dout_q [NREQ];

    // Pack requester operations
    assign op0 = '{al: req0_al, lr: req0_lr, din: req0_din, shamt: req0_shamt};
    assign op1 = '{al: req1_al, lr: req1_lr, din: req1_din, shamt: req1_shamt};

    assign req_valid = {req1_valid, req0_valid};
    assign rsp_ready = {rsp1_ready, rsp0_ready};

    // A full buffer being drained this cycle can take a new result.
    assign elig = req_valid & (~rsp_valid_q | rsp_ready);

    rr_arb2 u_arb (
        .elig  (elig),
        .last  (last),
        .grant (grant)
    );

    assign accept = grant & req_valid;

    // Shifter input mux; value is don't-care when nothing is granted
    assign sh_op = grant[1] ? op1 : op0;

    barrelshifter u_shift (
        .al    (sh_op.al),
        .lr    (sh_op.lr),
        .din   (sh_op.din),
        .shamt (sh_op.shamt),
        .dout  (sh_dout)
    );

    // Response buffers: accept wins over drain, so a streaming consumer sees 1 op/cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_valid_q <= '0;
            for (int i = 0; i < NREQ; i++) begin
                rsp_dout_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NREQ; i++) begin
                if (accept[i]) begin
                    rsp_valid_q[i] <= 1'b1;
                    rsp_dout_q[i]  <= sh_dout;
                end else if (rsp_ready[i]) begin
                    rsp_valid_q[i] <= 1'b0;
                end
            end
        end
    end

    // Last-served pointer; held on idle cycles
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last <= RR_INIT;
        end else if (|accept) begin
            last <= accept[1];
        end
    end

    assign req0_ready = grant[0];
    assign req1_ready = grant[1];
    assign rsp0_valid = rsp_valid_q[0];
    assign rsp1_valid = rsp_valid_q[1];
    assign rsp0_dout  = rsp_dout_q[0];
    assign rsp1_dout  = rsp_dout_q[1];

endmodule

// File: tb/tb_shift_arbiter.sv
module tb_shift_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic       req0_valid, req0_ready, req0_al, req0_lr;
    logic [7:0] req0_din;
    logic [2:0] req0_shamt;
    logic       rsp0_valid, rsp0_ready;
    logic [7:0] rsp0_dout;
    logic       req1_valid, req1_ready, req1_al, req1_lr;
    logic [7:0] req1_din;
    logic [2:0] req1_shamt;
    logic       rsp1_valid, rsp1_ready;
    logic [7:0] rsp1_dout;

    int n_cmp  = 0;
    int n_fail = 0;
    logic [7:0] q0[$];
    logic [7:0] q1[$];

    shift_arbiter #(.RR_INIT(1'b1)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_al(req0_al),
        .req0_lr(req0_lr), .req0_din(req0_din), .req0_shamt(req0_shamt),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_dout(rsp0_dout),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_al(req1_al),
        .req1_lr(req1_lr), .req1_din(req1_din), .req1_shamt(req1_shamt),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_dout(rsp1_dout)
    );

    always #5 clk = ~clk;

    function automatic void chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endfunction

    task automatic drv0(input logic v, input logic al, input logic lr, input logic [7:0] din, input logic [2:0] sh);
        req0_valid = v; req0_al = al; req0_lr = lr; req0_din = din; req0_shamt = sh;
    endtask

    task automatic drv1(input logic v, input logic al, input logic lr, input logic [7:0] din, input logic [2:0] sh);
        req1_valid = v; req1_al = al; req1_lr = lr; req1_din = din; req1_shamt = sh;
    endtask

    // Called at posedge+1 with inputs set; checks grants, queues expected results, advances one cycle.
    task automatic step(input logic er0, input logic er1, input logic [7:0] e0, input logic [7:0] e1);
        #1;
        chk("req0_ready", 8'(req0_ready), 8'(er0));
        chk("req1_ready", 8'(req1_ready), 8'(er1));
        if (er0) q0.push_back(e0);
        if (er1) q1.push_back(e1);
        @(posedge clk);
        #1;
    endtask

    // Monitor: every consumed response is matched against the scoreboard in order
    always @(negedge clk) begin
        if (!rst) begin
            if (rsp0_valid && rsp0_ready) begin
                if (q0.size() == 0) begin
                    n_cmp++; n_fail++;
                    $display("FAIL rsp0_unexpected: got %h expected no response", rsp0_dout);
                end else begin
                    chk("rsp0_dout", rsp0_dout, q0.pop_front());
                end
            end
            if (rsp1_valid && rsp1_ready) begin
                if (q1.size() == 0) begin
                    n_cmp++; n_fail++;
                    $display("FAIL rsp1_unexpected: got %h expected no response", rsp1_dout);
                end else begin
                    chk("rsp1_dout", rsp1_dout, q1.pop_front());
                end
            end
        end
    end

    initial begin
        rst = 1'b1;
        drv0(0, 0, 0, 8'h00, 3'd0);
        drv1(0, 0, 0, 8'h00, 3'd0);
        rsp0_ready = 1'b0;
        rsp1_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state
        chk("rst_rsp0_valid", 8'(rsp0_valid), 8'h00);
        chk("rst_rsp1_valid", 8'(rsp1_valid), 8'h00);
        chk("rst_rsp0_dout", rsp0_dout, 8'h00);
        chk("rst_rsp1_dout", rsp1_dout, 8'h00);

        // Single req0 op, 1-cycle latency
        rsp0_ready = 1'b1;
        drv0(1, 0, 1, 8'h81, 3'd1);
        step(1, 0, 8'h02, 8'h00);
        chk("lat_rsp0_valid", 8'(rsp0_valid), 8'h01);
        chk("lat_rsp0_dout", rsp0_dout, 8'h02);
        drv0(0, 0, 0, 8'h00, 3'd0);
        step(0, 0, 8'h00, 8'h00);
        chk("drain_rsp0_valid", 8'(rsp0_valid), 8'h00);

        // req1 back-to-back, arithmetic then logical right
        rsp1_ready = 1'b1;
        drv1(1, 1, 0, 8'h80, 3'd3);
        step(0, 1, 8'h00, 8'hF0);
        chk("b2b_rsp1_valid_a", 8'(rsp1_valid), 8'h01);
        drv1(1, 0, 0, 8'h80, 3'd3);
        step(0, 1, 8'h00, 8'h10);
        chk("b2b_rsp1_valid_b", 8'(rsp1_valid), 8'h01);
        chk("b2b_rsp1_dout_b", rsp1_dout, 8'h10);
        drv1(0, 0, 0, 8'h00, 3'd0);
        step(0, 0, 8'h00, 8'h00);

        // Fresh reset, then both requesters contend every cycle
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        drv0(1, 0, 1, 8'h01, 3'd1);
        drv1(1, 0, 0, 8'h80, 3'd1);
        step(1, 0, 8'h02, 8'h00);
        drv0(1, 0, 1, 8'h03, 3'd2);
        step(0, 1, 8'h00, 8'h40);
        drv1(1, 1, 0, 8'h80, 3'd2);
        step(1, 0, 8'h0C, 8'h00);
        drv0(1, 1, 0, 8'hF0, 3'd4);
        step(0, 1, 8'h00, 8'hE0);
        drv1(0, 0, 0, 8'h00, 3'd0);
        step(1, 0, 8'hFF, 8'h00);
        drv0(0, 0, 0, 8'h00, 3'd0);
        step(0, 0, 8'h00, 8'h00);

        // Back-pressure on rsp0: req1 takes every grant until rsp0_ready rises
        rsp0_ready = 1'b0;
        drv0(1, 0, 1, 8'h11, 3'd4);
        step(1, 0, 8'h10, 8'h00);
        drv0(1, 0, 0, 8'h22, 3'd1);
        drv1(1, 0, 1, 8'h0F, 3'd4);
        step(0, 1, 8'h00, 8'hF0);
        chk("bp_rsp0_dout_a", rsp0_dout, 8'h10);
        drv1(1, 0, 0, 8'hFF, 3'd7);
        step(0, 1, 8'h00, 8'h01);
        chk("bp_rsp0_dout_b", rsp0_dout, 8'h10);
        chk("bp_rsp0_valid", 8'(rsp0_valid), 8'h01);
        rsp0_ready = 1'b1;
        drv1(1, 1, 0, 8'h40, 3'd6);
        step(1, 0, 8'h11, 8'h00);
        drv0(0, 0, 0, 8'h00, 3'd0);
        step(0, 1, 8'h00, 8'h01);
        drv1(0, 0, 0, 8'h00, 3'd0);
        step(0, 0, 8'h00, 8'h00);

        // shamt = 0 passes din in every mode
        drv0(1, 0, 1, 8'hA5, 3'd0);
        step(1, 0, 8'hA5, 8'h00);
        drv0(1, 0, 0, 8'hA5, 3'd0);
        step(1, 0, 8'hA5, 8'h00);
        drv0(1, 1, 0, 8'hA5, 3'd0);
        step(1, 0, 8'hA5, 8'h00);
        drv0(0, 0, 0, 8'h00, 3'd0);
        step(0, 0, 8'h00, 8'h00);

        // Reset asserted while rsp0 is full and a req1 accept is pending
        rsp0_ready = 1'b0;
        drv0(1, 0, 1, 8'h01, 3'd0);
        step(1, 0, 8'h01, 8'h00);
        drv0(0, 0, 0, 8'h00, 3'd0);
        drv1(1, 0, 1, 8'h0F, 3'd1);
        #1;
        chk("pre_rst_req1_ready", 8'(req1_ready), 8'h01);
        rst = 1'b1;
        #1;
        chk("async_rst_rsp0_valid", 8'(rsp0_valid), 8'h00);
        chk("async_rst_rsp1_valid", 8'(rsp1_valid), 8'h00);
        chk("async_rst_rsp0_dout", rsp0_dout, 8'h00);
        q0.delete();
        q1.delete();
        @(posedge clk);
        #1 rst = 1'b0;
        drv1(0, 0, 0, 8'h00, 3'd0);
        rsp0_ready = 1'b1;
        step(0, 0, 8'h00, 8'h00);
        chk("post_rst_rsp1_valid", 8'(rsp1_valid), 8'h00);
        chk("post_rst_rsp0_valid", 8'(rsp0_valid), 8'h00);
        drv0(1, 0, 0, 8'h80, 3'd1);
        drv1(1, 1, 0, 8'h80, 3'd7);
        step(1, 0, 8'h40, 8'h00);
        drv0(0, 0, 0, 8'h00, 3'd0);
        step(0, 1, 8'h00, 8'hFF);
        drv1(0, 0, 0, 8'h00, 3'd0);
        step(0, 0, 8'h00, 8'h00);
        step(0, 0, 8'h00, 8'h00);

        chk("q0_left", 8'(q0.size()), 8'h00);
        chk("q1_left", 8'(q1.size()), 8'h00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/shift_arbiter.md
Name: shift_arbiter

Overview:
Shares one combinational 8-bit barrel shifter between two independent requesters. Each requester has a valid/ready request channel and a valid/ready response channel. A round-robin grant selects at most one request per cycle. The block drives the shared shifter, captures its result into a per-requester one-entry response buffer, and returns it with 1-cycle latency. It sits between the NPC shift users, such as the ALU and the load-align unit, and the single shifter instance.

Parameters:
RR_INIT, 1, index of the "last served" requester after reset. 1 means requester 0 wins the first tie.

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  reset, asynchronous, active-high
req0_valid  in  1  requester 0 has an operation
req0_ready  out  1  requester 0 operation accepted this cycle when high together with req0_valid
req0_al  in  1  1 = arithmetic right (fill din[7]); 0 = logical (fill 0)
req0_lr  in  1  1 = shift left, 0 = shift right
req0_din  in  8  operand
req0_shamt  in  3  shift amount, 0..7
rsp0_valid  out  1  response buffer 0 holds a result
rsp0_ready  in  1  requester 0 consumes result
rsp0_dout  out  8  shifted result
req1_valid, req1_ready, req1_al, req1_lr, req1_din, req1_shamt  same widths and meaning, requester 1
rsp1_valid, rsp1_ready, rsp1_dout  same widths and meaning, requester 1

Behaviour:
- Reset (async assert, any cycle):
  - rsp0_valid = rsp1_valid = 0; rsp*_dout = 0.
  - last = RR_INIT.
  - An in-flight accept in the reset cycle is discarded.
- Shift semantics (the shared shifter's semantics):
  - lr=1: logical left, zero fill; al is ignored.
  - lr=0, al=0: logical right.
  - lr=0, al=1: arithmetic right.
  - shamt=0 passes din unchanged.
- Eligibility: elig_i = req_i_valid & (~rsp_i_valid | rsp_i_ready). A full buffer being drained this cycle counts as free.
- Grant (combinational, one-hot or zero):
  - Only one requester eligible: it is granted.
  - Both eligible: grant = ~last, i.e. the requester not served most recently.
  - Neither eligible: no grant; the shifter inputs are don't-care and no state changes.
- req_i_ready = grant_i. ready may depend on the other requester's valid and on the rsp state. A requester must not drop valid before ready.
- The shifter input mux selects the granted requester's al/lr/din/shamt.
- Accept edge (grant_i & req_i_valid):
  - rsp_i_dout <= shifter result.
  - rsp_i_valid <= 1.
  - last <= i.
  - Latency is exactly 1: the result is visible the cycle after the accept.
- Drain: rsp_i_valid & rsp_i_ready with no new accept for i clears rsp_i_valid. rsp_i_dout holds its last value.
- Simultaneous drain and accept for the same i: rsp_i_valid stays 1 and dout is replaced. This gives a throughput of 1 op/cycle per requester while its consumer is always ready.
- Back-pressure:
  - rsp_i_valid=1 and rsp_i_ready=0 makes requester i ineligible.
  - The other requester receives every grant meanwhile.
  - last does not change on idle cycles.
- Starvation bound: a continuously eligible requester is granted within 2 cycles.
- Responses are never dropped or duplicated. Each accepted request yields exactly one response on its own channel, in order.
- Internal state: last (1 bit); rsp0_valid, rsp1_valid; rsp0_dout, rsp1_dout.

Decomposition:
- Package shift_pkg holds:
  - the shift_op_t struct {al, lr, din[7:0], shamt[2:0]};
  - NREQ=2;
  - DW=8 and SHW=3.
- Sub-module rr_arb2 holds the round-robin grant logic: inputs elig[1:0], last; output grant[1:0].
- The existing barrelshifter module is instantiated once, unmodified, as the shared datapath.
- Response buffers and the last register live in shift_arbiter.

Test Plan:
- After reset, req0 only: al=0, lr=1, din=0x81, shamt=1, rsp0_ready=1 -> req0_ready=1 same cycle; next cycle rsp0_valid=1, rsp0_dout=0x02.
- req1 only, two back-to-back ops with rsp1_ready=1:
  - first: lr=0, al=1, din=0x80, shamt=3 -> rsp1_dout=0xF0;
  - second: lr=0, al=0, din=0x80, shamt=3 -> rsp1_dout=0x10 on the following cycle, rsp1_valid continuously 1.
- Both valid every cycle from reset, both rsp_ready=1 -> grants alternate 0,1,0,1 (req0 first, RR_INIT=1); each response follows its grant by 1 cycle.
- rsp0_ready=0 after a req0 result, req0_valid held -> req0_ready=0 and rsp0_dout stable. req1 is granted every cycle. Raising rsp0_ready re-grants req0 in the same cycle.
- shamt=0 with din=0xA5 in each of the 3 modes -> dout=0xA5.
- Assert rst while rsp0_valid=1 and a req1 accept is in progress -> rsp*_valid=0 immediately. No response appears after reset release. The next tie grants req0.
